// File: rtl/mul_normalize_round_if.sv
// Handshake and data bundle between the multiplier significand stage and the
// normalise/round/pack stage, plus the result port.
interface mul_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign1;
  logic        sign2;
  logic [4:0]  exp1;
  logic [4:0]  exp2;
  logic        frac1_z;
  logic        frac2_z;
  logic [12:0] product;
  logic        carry_out;
  logic        round_loss;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_fp;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, sign1, sign2, exp1, exp2, frac1_z, frac2_z,
           product, carry_out, round_loss, out_ready,
    input  in_ready, out_valid, out_fp, out_flags
  );

  modport slave (
    input  in_valid, sign1, sign2, exp1, exp2, frac1_z, frac2_z,
           product, carry_out, round_loss, out_ready,
    output in_ready, out_valid, out_fp, out_flags
  );
endinterface

// File: rtl/mul_normalize_round.sv
// Binary16 multiply back end: exponent sum, class decode and normalise select
// (S1), then round-to-nearest-even, overflow/underflow handling and pack (S2).
module mul_normalize_round #(
  parameter bit SATURATE = 1'b0
) (
  input logic             clk,
  input logic             RST,
  mul_normalize_round_if.slave bus
);

  logic              s1_valid;
  logic              s1_sign;
  logic signed [6:0] s1_e;
  logic [9:0]        s1_frac;
  logic              s1_guard;
  logic              s1_sticky;
  logic              s1_invalid;
  logic              s1_inf;
  logic              s1_zero;

  logic              s2_valid;
  logic [15:0]       out_fp_q;
  logic [3:0]        out_flags_q;

  logic              s1_adv;
  logic              s1_load;

  assign s1_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign s1_load      = bus.in_valid && bus.in_ready;

  // S1 combinational decode of the incoming operands
  logic              nan1, nan2, inf1, inf2, zero1, zero2;
  logic signed [6:0] e_sum;
  logic [9:0]        frac_sel;
  logic              guard_sel;
  logic              sticky_sel;

  assign nan1  = (bus.exp1 == 5'd31) && !bus.frac1_z;
  assign nan2  = (bus.exp2 == 5'd31) && !bus.frac2_z;
  assign inf1  = (bus.exp1 == 5'd31) &&  bus.frac1_z;
  assign inf2  = (bus.exp2 == 5'd31) &&  bus.frac2_z;
  assign zero1 = (bus.exp1 == 5'd0);
  assign zero2 = (bus.exp2 == 5'd0);

  assign e_sum = signed'({2'b00, bus.exp1}) + signed'({2'b00, bus.exp2})
               + signed'({6'd0, bus.carry_out}) - 7'sd15;

  assign frac_sel   = bus.carry_out ? bus.product[12:3] : bus.product[11:2];
  assign guard_sel  = bus.carry_out ? bus.product[2]    : bus.product[1];
  assign sticky_sel = bus.carry_out ? ((|bus.product[1:0]) | bus.round_loss)
                                    : (bus.product[0] | bus.round_loss);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_e       <= '0;
      s1_frac    <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
      s1_invalid <= 1'b0;
      s1_inf     <= 1'b0;
      s1_zero    <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (s1_load) begin
        s1_sign    <= bus.sign1 ^ bus.sign2;
        s1_e       <= e_sum;
        s1_frac    <= frac_sel;
        s1_guard   <= guard_sel;
        s1_sticky  <= sticky_sel;
        s1_invalid <= nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1);
        s1_inf     <= inf1 || inf2;
        s1_zero    <= zero1 || zero2;
      end
    end
  end

  // S2 round and pack
  logic              round_up;
  logic [10:0]       frac_r;
  logic signed [6:0] e_r;
  logic [15:0]       res_fp;
  logic [3:0]        res_flags;

  assign round_up = s1_guard && (s1_sticky || s1_frac[0]);
  assign frac_r   = {1'b0, s1_frac} + {10'd0, round_up};
  assign e_r      = s1_e + signed'({6'd0, frac_r[10]});

  always_comb begin
    res_fp    = {s1_sign, e_r[4:0], frac_r[9:0]};
    res_flags = {3'b000, s1_guard || s1_sticky};
    if (s1_invalid) begin
      res_fp    = 16'h7E00;
      res_flags = 4'b1000;
    end else if (s1_inf) begin
      res_fp    = {s1_sign, 15'h7C00};
      res_flags = 4'b0000;
    end else if (s1_zero) begin
      res_fp    = {s1_sign, 15'h0000};
      res_flags = 4'b0000;
    end else if (s1_e <= 7'sd0) begin
      // flush: subnormal results are not produced
      res_fp    = {s1_sign, 15'h0000};
      res_flags = 4'b0010;
    end else if (e_r >= 7'sd31) begin
      res_fp    = SATURATE ? {s1_sign, 15'h7BFF} : {s1_sign, 15'h7C00};
      res_flags = 4'b0101;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s2_valid    <= 1'b0;
      out_fp_q    <= 16'h0000;
      out_flags_q <= 4'h0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_fp_q    <= res_fp;
        out_flags_q <= res_flags;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_fp    = out_fp_q;
  assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_mul_normalize_round.sv
// Self-checking bench for mul_normalize_round: directed corner cases, a
// randomized stream against an arithmetic reference model, backpressure and reset.
module tb_mul_normalize_round;

  typedef struct packed {
    logic        s1;
    logic        s2;
    logic [4:0]  e1;
    logic [4:0]  e2;
    logic        z1;
    logic        z2;
    logic [12:0] p;
    logic        c;
    logic        rl;
  } stim_t;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  mul_normalize_round_if ifa ();
  mul_normalize_round_if ifb ();

  // second instance (saturating) sees exactly the same stimulus and handshake
  assign ifb.in_valid   = ifa.in_valid;
  assign ifb.sign1      = ifa.sign1;
  assign ifb.sign2      = ifa.sign2;
  assign ifb.exp1       = ifa.exp1;
  assign ifb.exp2       = ifa.exp2;
  assign ifb.frac1_z    = ifa.frac1_z;
  assign ifb.frac2_z    = ifa.frac2_z;
  assign ifb.product    = ifa.product;
  assign ifb.carry_out  = ifa.carry_out;
  assign ifb.round_loss = ifa.round_loss;
  assign ifb.out_ready  = ifa.out_ready;

  mul_normalize_round #(.SATURATE(1'b0)) dut     (.clk(clk), .RST(RST), .bus(ifa));
  mul_normalize_round #(.SATURATE(1'b1)) dut_sat (.clk(clk), .RST(RST), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic stim_t mk(bit s1, bit s2, int e1, int e2, bit z1, bit z2,
                               logic [12:0] p, bit c, bit rl);
    stim_t s;
    s.s1 = s1; s.s2 = s2; s.e1 = e1[4:0]; s.e2 = e2[4:0];
    s.z1 = z1; s.z2 = z2; s.p = p; s.c = c; s.rl = rl;
    return s;
  endfunction

  // Reference: value-level classification, then integer rounding of the
  // significand {carry,product} to 11 bits with round-half-even.
  function automatic logic [19:0] model(stim_t s, bit sat);
    bit sgn, nan1, nan2, inf1, inf2, zr1, zr2, up, inexact;
    int ex, m, sh, kept, rem, half;
    sgn  = s.s1 ^ s.s2;
    nan1 = (s.e1 == 31) && !s.z1;
    nan2 = (s.e2 == 31) && !s.z2;
    inf1 = (s.e1 == 31) && s.z1;
    inf2 = (s.e2 == 31) && s.z2;
    zr1  = (s.e1 == 0);
    zr2  = (s.e2 == 0);
    if (nan1 || nan2 || (inf1 && zr2) || (inf2 && zr1)) return {16'h7E00, 4'b1000};
    if (inf1 || inf2) return {sgn, 15'h7C00, 4'b0000};
    if (zr1 || zr2) return {sgn, 15'h0000, 4'b0000};
    ex = int'(s.e1) + int'(s.e2) - 15 + int'(s.c);
    if (ex <= 0) return {sgn, 15'h0000, 4'b0010};
    m    = int'({s.c, s.p});
    sh   = s.c ? 3 : 2;
    kept = m >> sh;
    rem  = m % (1 << sh);
    half = 1 << (sh - 1);
    up   = (rem > half) || (rem == half && (s.rl || (kept % 2 == 1)));
    inexact = (rem != 0) || s.rl;
    kept = kept + int'(up);
    if (kept >= 2048) begin
      kept = kept / 2;
      ex   = ex + 1;
    end
    if (ex >= 31) return {sgn, (sat ? 15'h7BFF : 15'h7C00), 4'b0101};
    return {sgn, ex[4:0], kept[9:0], 3'b000, inexact};
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int r;
    s.s1 = 1'($urandom_range(0, 1));
    s.s2 = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    s.e1 = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(1, 30));
    r = $urandom_range(0, 9);
    s.e2 = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(1, 30));
    s.z1 = 1'($urandom_range(0, 1));
    s.z2 = 1'($urandom_range(0, 1));
    s.c  = 1'($urandom_range(0, 1));
    s.p  = 13'($urandom);
    if (!s.c) s.p[12] = 1'b1;
    if ($urandom_range(0, 3) == 0) begin
      if (s.c) s.p[2:0] = 3'b100;
      else     s.p[1:0] = 2'b10;
    end
    s.rl = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ifa.sign1      = s.s1;
    ifa.sign2      = s.s2;
    ifa.exp1       = s.e1;
    ifa.exp2       = s.e2;
    ifa.frac1_z    = s.z1;
    ifa.frac2_z    = s.z2;
    ifa.product    = s.p;
    ifa.carry_out  = s.c;
    ifa.round_loss = s.rl;
  endtask

  // single transaction through an empty pipe; returns results and latency
  task automatic do_one(input stim_t s, output logic [15:0] fp, output logic [15:0] fps,
                        output logic [3:0] fl, output logic [3:0] fls, output int lat);
    ifa.out_ready = 1'b1;
    drive(s);
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ifa.out_valid) break;
    end
    fp  = ifa.out_fp;
    fl  = ifa.out_flags;
    fps = ifb.out_fp;
    fls = ifb.out_flags;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 1, 1, 13'h0, 0, 0));
    RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ifa.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_out_valid got %b want 0", ifa.out_valid);
    end
    n_tests++;
    if (ifa.out_fp !== 16'h0000) begin
      n_fail++; $display("FAIL rst_out_fp got %h want 0000", ifa.out_fp);
    end
    n_tests++;
    if (ifa.out_flags !== 4'h0) begin
      n_fail++; $display("FAIL rst_out_flags got %b want 0000", ifa.out_flags);
    end
    @(negedge clk) RST = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (ifa.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready got %b want 1", ifa.in_ready);
    end
  endtask

  task automatic test_directed();
    stim_t       v [14];
    logic [15:0] want_fp [14];
    logic [15:0] want_fps[14];
    logic [3:0]  want_fl [14];
    logic [15:0] fp, fps;
    logic [3:0]  fl, fls;
    int          lat;
    v[0]  = mk(0, 0, 15, 15, 1, 1, 13'h1000, 0, 0); want_fp[0]  = 16'h3C00; want_fps[0]  = 16'h3C00; want_fl[0]  = 4'b0000;
    v[1]  = mk(0, 0, 15, 15, 0, 0, 13'h0400, 1, 0); want_fp[1]  = 16'h4080; want_fps[1]  = 16'h4080; want_fl[1]  = 4'b0000;
    v[2]  = mk(1, 0, 15, 15, 0, 0, 13'h0400, 1, 0); want_fp[2]  = 16'hC080; want_fps[2]  = 16'hC080; want_fl[2]  = 4'b0000;
    v[3]  = mk(0, 0, 15, 15, 0, 0, 13'h1002, 0, 0); want_fp[3]  = 16'h3C00; want_fps[3]  = 16'h3C00; want_fl[3]  = 4'b0001;
    v[4]  = mk(0, 0, 15, 15, 0, 0, 13'h1006, 0, 0); want_fp[4]  = 16'h3C02; want_fps[4]  = 16'h3C02; want_fl[4]  = 4'b0001;
    v[5]  = mk(1, 0, 30, 30, 1, 1, 13'h1000, 0, 0); want_fp[5]  = 16'hFC00; want_fps[5]  = 16'hFBFF; want_fl[5]  = 4'b0101;
    v[6]  = mk(0, 0, 31,  0, 1, 1, 13'h1000, 0, 0); want_fp[6]  = 16'h7E00; want_fps[6]  = 16'h7E00; want_fl[6]  = 4'b1000;
    v[7]  = mk(0, 0, 31, 15, 0, 1, 13'h1000, 0, 0); want_fp[7]  = 16'h7E00; want_fps[7]  = 16'h7E00; want_fl[7]  = 4'b1000;
    v[8]  = mk(0, 0,  3,  5, 1, 1, 13'h1000, 0, 0); want_fp[8]  = 16'h0000; want_fps[8]  = 16'h0000; want_fl[8]  = 4'b0010;
    v[9]  = mk(1, 0, 31, 15, 1, 1, 13'h1000, 0, 0); want_fp[9]  = 16'hFC00; want_fps[9]  = 16'hFC00; want_fl[9]  = 4'b0000;
    v[10] = mk(1, 0,  0, 15, 1, 1, 13'h1000, 0, 0); want_fp[10] = 16'h8000; want_fps[10] = 16'h8000; want_fl[10] = 4'b0000;
    v[11] = mk(0, 0, 15, 15, 0, 0, 13'h1FFE, 0, 0); want_fp[11] = 16'h4000; want_fps[11] = 16'h4000; want_fl[11] = 4'b0001;
    v[12] = mk(0, 0, 30, 15, 0, 0, 13'h1FFE, 0, 0); want_fp[12] = 16'h7C00; want_fps[12] = 16'h7BFF; want_fl[12] = 4'b0101;
    v[13] = mk(0, 0,  8,  8, 1, 1, 13'h1000, 0, 0); want_fp[13] = 16'h0400; want_fps[13] = 16'h0400; want_fl[13] = 4'b0000;
    for (int i = 0; i < 14; i++) begin
      do_one(v[i], fp, fps, fl, fls, lat);
      n_tests++;
      if (lat !== 2) begin
        n_fail++; $display("FAIL dir%0d_latency got %0d want 2", i, lat);
      end
      n_tests++;
      if (fp !== want_fp[i]) begin
        n_fail++; $display("FAIL dir%0d_fp got %h want %h", i, fp, want_fp[i]);
      end
      n_tests++;
      if (fl !== want_fl[i]) begin
        n_fail++; $display("FAIL dir%0d_flags got %b want %b", i, fl, want_fl[i]);
      end
      n_tests++;
      if (fps !== want_fps[i] || fls !== want_fl[i]) begin
        n_fail++; $display("FAIL dir%0d_sat got %h/%b want %h/%b", i, fps, fls, want_fps[i], want_fl[i]);
      end
    end
  endtask

  task automatic test_random(input int n);
    stim_t       cur;
    bit          pending = 0;
    bit          stall = 0;
    bit          acc;
    int          sent = 0;
    int          cyc = 0;
    logic [19:0] held = '0;
    logic [19:0] q_n[$];
    logic [19:0] q_s[$];
    logic [19:0] e_n, e_s;
    while ((sent < n || q_n.size() != 0) && cyc < 8000) begin
      if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
        cur = rand_stim();
        drive(cur);
        ifa.in_valid = 1'b1;
        pending = 1;
      end
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stall) begin
        n_tests++;
        if (ifa.out_valid !== 1'b1 || {ifa.out_fp, ifa.out_flags} !== held) begin
          n_fail++; $display("FAIL rnd_hold got %b/%h want 1/%h", ifa.out_valid, {ifa.out_fp, ifa.out_flags}, held);
        end
      end
      if (ifa.out_valid && ifa.out_ready) begin
        n_tests++;
        if (q_n.size() == 0) begin
          n_fail++; $display("FAIL rnd_unexpected got %h want no output", ifa.out_fp);
        end else begin
          e_n = q_n.pop_front();
          e_s = q_s.pop_front();
          if ({ifa.out_fp, ifa.out_flags} !== e_n) begin
            n_fail++; $display("FAIL rnd_result got %h/%b want %h/%b", ifa.out_fp, ifa.out_flags, e_n[19:4], e_n[3:0]);
          end
          n_tests++;
          if ({ifb.out_fp, ifb.out_flags} !== e_s) begin
            n_fail++; $display("FAIL rnd_sat_result got %h/%b want %h/%b", ifb.out_fp, ifb.out_flags, e_s[19:4], e_s[3:0]);
          end
        end
      end
      stall = ifa.out_valid && !ifa.out_ready;
      held  = {ifa.out_fp, ifa.out_flags};
      acc   = ifa.in_valid && ifa.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        q_n.push_back(model(cur, 1'b0));
        q_s.push_back(model(cur, 1'b1));
        pending = 0;
        sent++;
        ifa.in_valid = 1'b0;
      end
      cyc++;
    end
    n_tests++;
    if (sent != n || q_n.size() != 0) begin
      n_fail++; $display("FAIL rnd_timeout got sent=%0d pending=%0d want sent=%0d pending=0", sent, q_n.size(), n);
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    stim_t       bp [3];
    logic [19:0] ex [3];
    int          k = 0;
    int          cyc = 0;
    bit          acc;
    for (int i = 0; i < 3; i++) begin
      bp[i] = rand_stim();
      ex[i] = model(bp[i], 1'b0);
    end
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(bp[i]);
      ifa.in_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ifa.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL bp_accept%0d got in_ready=%b want 1", i, ifa.in_ready);
      end
      @(posedge clk);
      #1;
    end
    drive(bp[2]);
    ifa.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (ifa.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_full got in_ready=%b want 0", ifa.in_ready);
      end
      n_tests++;
      if (ifa.out_valid !== 1'b1 || {ifa.out_fp, ifa.out_flags} !== ex[0]) begin
        n_fail++; $display("FAIL bp_head got %b/%h want 1/%h", ifa.out_valid, {ifa.out_fp, ifa.out_flags}, ex[0]);
      end
    end
    @(posedge clk);
    #1 ifa.out_ready = 1'b1;
    while (k < 3 && cyc < 20) begin
      @(negedge clk);
      acc = ifa.in_valid && ifa.in_ready;
      if (ifa.out_valid) begin
        n_tests++;
        if ({ifa.out_fp, ifa.out_flags} !== ex[k]) begin
          n_fail++; $display("FAIL bp_order%0d got %h want %h", k, {ifa.out_fp, ifa.out_flags}, ex[k]);
        end
        k++;
      end
      @(posedge clk);
      #1;
      if (acc) ifa.in_valid = 1'b0;
      cyc++;
    end
    n_tests++;
    if (k != 3) begin
      n_fail++; $display("FAIL bp_count got %0d want 3", k);
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_stim());
      ifa.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    ifa.in_valid = 1'b0;
    @(negedge clk);
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if (ifa.out_valid !== 1'b0 || ifa.out_fp !== 16'h0000 || ifa.out_flags !== 4'h0) begin
      n_fail++; $display("FAIL midrst_clear got %b/%h/%b want 0/0000/0000", ifa.out_valid, ifa.out_fp, ifa.out_flags);
    end
    @(negedge clk) RST = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrst_stale got %0d outputs want 0", seen);
    end
    n_tests++;
    if (ifa.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready got %b want 1", ifa.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    RST = 1'b1;
    test_reset();
    test_directed();
    test_random(400);
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
